c_isa_data_mem: RTL

C_ISA_DATA_MEM -- requirements
Module: c_isa_data_mem

---
 rtl/c_isa_data_mem.sv | 86 ++++++++
 1 files changed

// File: rtl/c_isa_data_mem.sv
// c_isa_data_mem: responder end of the core's data-memory port.
// Word-addressed array behind a byte-address interface. Writes land at the
// sampling edge; reads return one cycle later with write-first forwarding.
// Rejected accesses (misaligned or out of range) raise a one-cycle error pulse.
module c_isa_data_mem #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        risc_clk,
  input  logic        risc_rst,
  input  logic        data_mem_write_en_i,
  input  logic [31:0] data_mem_write_addr_i,
  input  logic [31:0] data_mem_write_data_i,
  input  logic        data_mem_read_en_i,
  input  logic [31:0] data_mem_read_addr_i,
  output logic [31:0] data_mem_read_data_o,
  output logic        data_mem_read_valid_o,
  output logic        data_mem_err_o,
  output logic [15:0] wr_count_o,
  output logic [15:0] rd_count_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  // Byte span of the window, one bit wider than an address so it never wraps.
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  logic [31:0] mem [DEPTH];

  // Offsets are computed with a borrow bit: an address below BASE_ADDR
  // produces a value of at least 2^32, which always fails the span check.
  logic [32:0]   wr_off;
  logic [32:0]   rd_off;
  logic          wr_ok;
  logic          rd_ok;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          wr_fire;
  logic          rd_fire;
  logic [31:0]   rd_word;

  // Address decode, legality and write-first read data selection.
  always_comb begin
    wr_off  = {1'b0, data_mem_write_addr_i} - {1'b0, BASE_ADDR};
    rd_off  = {1'b0, data_mem_read_addr_i} - {1'b0, BASE_ADDR};
    wr_ok   = (data_mem_write_addr_i[1:0] == 2'b00) && (wr_off < SPAN);
    rd_ok   = (data_mem_read_addr_i[1:0] == 2'b00) && (rd_off < SPAN);
    wr_idx  = wr_off[AW+1:2];
    rd_idx  = rd_off[AW+1:2];
    // The array has no reset branch, so reset gating is applied here to keep
    // requests presented during reset from touching it.
    wr_fire = risc_rst && data_mem_write_en_i && wr_ok;
    rd_fire = data_mem_read_en_i && rd_ok;
    // A same-index write in this cycle wins over the stored word.
    if (wr_fire && (wr_idx == rd_idx)) rd_word = data_mem_write_data_i;
    else                               rd_word = mem[rd_idx];
  end

  // Storage array write port.
  // NOTE: the array is deliberately left out of reset; clearing a RAM would
  // force it into flops, and its contents must survive a reset anyway.
  always_ff @(posedge risc_clk) begin
    if (wr_fire) mem[wr_idx] <= data_mem_write_data_i;
  end

  // Registered read response, error pulse and saturating access counters.
  // NOTE: every register here uses non-blocking assignment so all of them
  // see the same pre-edge values regardless of statement order.
  always_ff @(posedge risc_clk or negedge risc_rst) begin
    if (!risc_rst) begin
      data_mem_read_data_o  <= 32'h0;
      data_mem_read_valid_o <= 1'b0;
      data_mem_err_o        <= 1'b0;
      wr_count_o            <= 16'h0;
      rd_count_o            <= 16'h0;
    end else begin
      data_mem_read_valid_o <= data_mem_read_en_i;
      data_mem_err_o        <= (data_mem_write_en_i && !wr_ok) ||
                               (data_mem_read_en_i && !rd_ok);
      // Read data only moves on a read; it holds otherwise.
      if (data_mem_read_en_i) data_mem_read_data_o <= rd_ok ? rd_word : 32'h0;
      if (wr_fire && (wr_count_o != 16'hFFFF)) wr_count_o <= wr_count_o + 16'd1;
      if (rd_fire && (rd_count_o != 16'hFFFF)) rd_count_o <= rd_count_o + 16'd1;
    end
  end

endmodule
